// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filters SCL/SDA, detects START/rSTART/STOP, reassembles
// bytes with their ACK bit and raises sticky protocol error flags.
module i2c_bus_monitor #(
  parameter int FILTER_LEN  = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 8
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             scl_i,
  input  logic             sda_i,
  input  logic             clear_err,
  output logic             start_pulse,
  output logic             rstart_pulse,
  output logic             stop_pulse,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_ack,
  output logic             byte_first,
  output logic [CNT_W-1:0] byte_count,
  output logic             bus_busy,
  output logic [3:0]       err_flags
);

  localparam int FC_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {BUS_FREE, ACTIVE} state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]            raw;
  logic [1:0]            s1_q, s2_q, f_q, fp_q;
  logic [1:0][FC_W-1:0]  fcnt_q;

  assign raw = {sda_i, scl_i};

  // Filtered line flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      f_q    <= 2'b11;
      fp_q   <= 2'b11;
      fcnt_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      fp_q <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FC_W'(FILTER_LEN - 1)) begin
          f_q[i]    <= s2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, scl_p, sda_f, sda_p;
  logic scl_rise, start_c, stop_c;

  assign scl_f    = f_q[0];
  assign scl_p    = fp_q[0];
  assign sda_f    = f_q[1];
  assign sda_p    = fp_q[1];
  assign scl_rise = scl_f & ~scl_p;
  // SCL must be stable high in both cycles, so a simultaneous SCL edge suppresses these
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

  state_t           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  low_q, low_d;
  logic [3:0]       err_q, err_d, err_set;
  logic             start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
  logic             bv_q, bv_d, ack_q, ack_d, bfirst_q, bfirst_d;
  logic [7:0]       data_q, data_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    low_d     = '0;
    err_set   = '0;
    start_d   = 1'b0;
    rstart_d  = 1'b0;
    stop_d    = 1'b0;
    bv_d      = 1'b0;
    data_d    = data_q;
    ack_d     = ack_q;
    bfirst_d  = bfirst_q;
    if (!enable) begin
      state_d = BUS_FREE;
    end else begin
      case (state_q)
        BUS_FREE: begin
          if (start_c) begin
            start_d   = 1'b1;
            bit_cnt_d = '0;
            cnt_d     = '0;
            first_d   = 1'b1;
            state_d   = ACTIVE;
          end else if (scl_rise) begin
            err_set[2] = 1'b1;
          end
        end
        ACTIVE: begin
          if (start_c) begin
            rstart_d   = 1'b1;
            first_d    = 1'b1;
            cnt_d      = '0;
            err_set[0] = (bit_cnt_q != 4'd0);
            bit_cnt_d  = '0;
          end else if (stop_c) begin
            stop_d     = 1'b1;
            err_set[0] = (bit_cnt_q != 4'd0);
            state_d    = BUS_FREE;
          end else if (scl_rise) begin
            if (bit_cnt_q != 4'd8) begin
              shreg_d   = {shreg_q[6:0], sda_f};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              bv_d      = 1'b1;
              data_d    = shreg_q;
              ack_d     = sda_f;
              bfirst_d  = first_q;
              first_d   = 1'b0;
              bit_cnt_d = '0;
              if (&cnt_q) err_set[3] = 1'b1;
              else        cnt_d      = cnt_q + 1'b1;
            end
          end else if (!scl_f) begin
            if (low_q == TO_W'(TIMEOUT_CYC - 1)) begin
              err_set[1] = 1'b1;
              state_d    = BUS_FREE;
            end else begin
              low_d = low_q + 1'b1;
            end
          end
        end
        default: state_d = BUS_FREE;
      endcase
    end
    err_d = (err_q & ~{4{clear_err}}) | err_set;
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q   <= BUS_FREE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      first_q   <= 1'b0;
      cnt_q     <= '0;
      low_q     <= '0;
      err_q     <= '0;
      start_q   <= 1'b0;
      rstart_q  <= 1'b0;
      stop_q    <= 1'b0;
      bv_q      <= 1'b0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      bfirst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      first_q   <= first_d;
      cnt_q     <= cnt_d;
      low_q     <= low_d;
      err_q     <= err_d;
      start_q   <= start_d;
      rstart_q  <= rstart_d;
      stop_q    <= stop_d;
      bv_q      <= bv_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      bfirst_q  <= bfirst_d;
    end
  end

  assign start_pulse  = start_q;
  assign rstart_pulse = rstart_q;
  assign stop_pulse   = stop_q;
  assign byte_valid   = bv_q;
  assign byte_data    = data_q;
  assign byte_ack     = ack_q;
  assign byte_first   = bfirst_q;
  assign byte_count   = cnt_q;
  assign bus_busy     = (state_q == ACTIVE);
  assign err_flags    = err_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: bit-level bus driver with a transaction-level model feeding
// an event scoreboard, plus sticky-error and reset checks.
module tb_i2c_bus_monitor;

  localparam int FL = 3;
  localparam int TO = 64;
  localparam int CW = 2;
  localparam int H  = 6;

  logic          system_clock = 1'b0;
  logic          reset, enable, scl_i, sda_i, clear_err;
  logic          start_pulse, rstart_pulse, stop_pulse, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ack, byte_first, bus_busy;
  logic [CW-1:0] byte_count;
  logic [3:0]    err_flags;

  i2c_bus_monitor #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .system_clock(system_clock), .reset(reset), .enable(enable),
    .scl_i(scl_i), .sda_i(sda_i), .clear_err(clear_err),
    .start_pulse(start_pulse), .rstart_pulse(rstart_pulse), .stop_pulse(stop_pulse),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ack(byte_ack),
    .byte_first(byte_first), .byte_count(byte_count), .bus_busy(bus_busy),
    .err_flags(err_flags)
  );

  always #5 system_clock = ~system_clock;

  typedef struct packed {
    logic [1:0]    kind;  // 0 START, 1 RSTART, 2 STOP, 3 BYTE
    logic [7:0]    data;
    logic          ack;
    logic          first;
    logic [CW-1:0] cnt;
  } ev_t;

  ev_t q[$];
  int  nchk, npass;

  // model of the bus as seen by the monitor
  logic          m_scl, m_sda, m_active, m_first, m_en;
  logic [7:0]    m_shreg;
  int            m_bits, m_low;
  logic [CW-1:0] m_cnt;
  logic [3:0]    m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void push(input logic [1:0] k, input logic [7:0] d, input logic a,
                               input logic f, input logic [CW-1:0] c);
    ev_t e;
    e = '{kind: k, data: d, ack: a, first: f, cnt: c};
    q.push_back(e);
  endfunction

  task automatic hold(input int n);
    repeat (n) @(posedge system_clock);
    #1;
    if (m_en && m_active && !m_scl) begin
      m_low += n;
      if (m_low >= TO) begin
        m_active = 1'b0;
        m_err[1] = 1'b1;
      end
    end
  endtask

  // change one line, let the model react to the resulting bus condition, then wait
  task automatic set_line(input bit is_scl, input logic v);
    logic os, od;
    os = m_scl;
    od = m_sda;
    if (is_scl) begin scl_i = v; m_scl = v; end
    else        begin sda_i = v; m_sda = v; end
    if (m_en) begin
      if (is_scl && !os && v) begin
        m_low = 0;
        if (!m_active) m_err[2] = 1'b1;
        else if (m_bits < 8) begin
          m_shreg = {m_shreg[6:0], m_sda};
          m_bits++;
        end else begin
          if (m_cnt == {CW{1'b1}}) m_err[3] = 1'b1;
          else m_cnt++;
          push(2'd3, m_shreg, m_sda, m_first, m_cnt);
          m_first = 1'b0;
          m_bits  = 0;
        end
      end else if (!is_scl && m_scl && od != v) begin
        if (!v) begin
          if (m_active) begin
            push(2'd1, 8'h0, 1'b0, 1'b0, '0);
            if (m_bits != 0) m_err[0] = 1'b1;
          end else push(2'd0, 8'h0, 1'b0, 1'b0, '0);
          m_active = 1'b1;
          m_bits   = 0;
          m_cnt    = '0;
          m_first  = 1'b1;
          m_low    = 0;
        end else if (m_active) begin
          push(2'd2, 8'h0, 1'b0, 1'b0, '0);
          if (m_bits != 0) m_err[0] = 1'b1;
          m_active = 1'b0;
        end
      end
    end
    hold(H);
  endtask

  // clock out b[n-1:0] MSB first; keep_high leaves SCL high after the last bit
  task automatic clk_bits(input logic [8:0] b, input int n, input bit keep_high);
    for (int i = n - 1; i >= 0; i--) begin
      if (m_sda != b[i]) set_line(1'b0, b[i]);
      set_line(1'b1, 1'b1);
      if (!(keep_high && i == 0)) set_line(1'b1, 1'b0);
    end
  endtask

  // START/rSTART need SCL=SDA=1; STOP needs SCL=1, SDA=0
  task automatic do_start();
    set_line(1'b0, 1'b0);
    set_line(1'b1, 1'b0);
  endtask

  task automatic do_stop();
    set_line(1'b0, 1'b1);
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    @(posedge system_clock);
    #1;
    clear_err = 1'b0;
    m_err = '0;
    hold(2);
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, {start_pulse, rstart_pulse, stop_pulse, byte_valid, byte_data, byte_ack,
               byte_first, byte_count, bus_busy, err_flags}, 32'h0);
  endtask

  initial begin
    nchk = 0; npass = 0;
    reset = 1'b1; enable = 1'b1; clear_err = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    m_scl = 1'b1; m_sda = 1'b1; m_active = 1'b0; m_first = 1'b0; m_en = 1'b1;
    m_shreg = '0; m_bits = 0; m_low = 0; m_cnt = '0; m_err = '0;

    fork
      begin : monitor
        ev_t a, e;
        forever begin
          @(negedge system_clock);
          if (!reset && (start_pulse | rstart_pulse | stop_pulse | byte_valid)) begin
            chk("pulse_onehot", $countones({start_pulse, rstart_pulse, stop_pulse, byte_valid}), 1);
            a = '0;
            a.kind = byte_valid ? 2'd3 : stop_pulse ? 2'd2 : rstart_pulse ? 2'd1 : 2'd0;
            if (byte_valid) begin
              a.data = byte_data; a.ack = byte_ack; a.first = byte_first; a.cnt = byte_count;
            end
            if (q.size() == 0) begin
              nchk++;
              $display("FAIL unexpected_event: got %0h expected none at %0t", a, $time);
            end else begin
              e = q.pop_front();
              chk("event", a, e);
            end
          end
        end
      end
    join_none

    @(negedge system_clock);
    @(negedge system_clock);
    chk_outs_zero("reset_outputs");
    @(posedge system_clock);
    #1 reset = 1'b0;
    hold(H);
    chk("idle_err", err_flags, 4'h0);

    // write A0 + 5A, both ACKed, STOP
    do_start();
    clk_bits({8'hA0, 1'b0}, 9, 1'b0);
    clk_bits({8'h5A, 1'b0}, 9, 1'b1);
    do_stop();
    chk("write_err", err_flags, 4'h0);
    chk("write_busy", bus_busy, 1'b0);

    // read A1 (NACK), rSTART, A0
    do_start();
    clk_bits({8'hA1, 1'b1}, 9, 1'b1);
    chk("busy_mid", bus_busy, 1'b1);
    do_start();
    clk_bits({8'hA0, 1'b0}, 9, 1'b1);
    do_stop();
    chk("rstart_err", err_flags, 4'h0);

    // STOP after 4 data bits
    do_start();
    clk_bits(9'b1010, 4, 1'b1);
    do_stop();
    chk("framing_err", err_flags, 4'b0001);
    do_clear();
    chk("framing_clr", err_flags, 4'h0);

    // SCL stuck low mid-byte
    do_start();
    clk_bits(9'b110, 3, 1'b0);
    hold(100);
    chk("timeout_err", err_flags, 4'b0010);
    chk("timeout_busy", bus_busy, 1'b0);
    set_line(1'b0, 1'b1);
    set_line(1'b1, 1'b1);
    chk("timeout_recover_err", err_flags, m_err);
    do_clear();

    // 1-cycle SDA glitch while SCL high, then stray SCL pulse on idle bus
    sda_i = 1'b0;
    @(posedge system_clock);
    #1 sda_i = 1'b1;
    hold(3 * H);
    chk("glitch_err", err_flags, 4'h0);
    chk("glitch_busy", bus_busy, 1'b0);
    set_line(1'b1, 1'b0);
    set_line(1'b1, 1'b1);
    chk("stray_err", err_flags, 4'b0100);
    do_clear();

    // four bytes in one frame saturate a 2-bit counter
    do_start();
    for (int i = 0; i < 3; i++) clk_bits({8'(8'h11 * (i + 1)), 1'b0}, 9, 1'b0);
    clk_bits({8'h44, 1'b0}, 9, 1'b1);
    chk("sat_count", byte_count, 2'd3);
    do_stop();
    chk("sat_err", err_flags, 4'b1000);
    do_clear();

    // enable dropped mid-frame
    do_start();
    clk_bits({8'h3C, 1'b0}, 9, 1'b0);
    clk_bits(9'b101, 3, 1'b0);
    enable = 1'b0; m_en = 1'b0; m_active = 1'b0;
    hold(H);
    chk("disable_busy", bus_busy, 1'b0);
    clk_bits(9'b10110, 5, 1'b0);
    set_line(1'b0, 1'b1);
    set_line(1'b1, 1'b1);
    enable = 1'b1; m_en = 1'b1;
    hold(H);
    chk("disable_err", err_flags, m_err);

    // randomized frames
    for (int f = 0; f < 16; f++) begin
      int segs;
      segs = $urandom_range(1, 2);
      do_start();
      for (int s = 0; s < segs; s++) begin
        int nb;
        logic last;
        logic [8:0] pb;
        nb = $urandom_range(0, 3);
        repeat (nb) clk_bits({8'($urandom), 1'($urandom)}, 9, 1'b0);
        last = (s == segs - 1) ? 1'b0 : 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          pb = 9'($urandom);
          pb[0] = last;
          clk_bits(pb, $urandom_range(1, 7), 1'b1);
        end else begin
          clk_bits({8'($urandom), last}, 9, 1'b1);
        end
        if (s < segs - 1) do_start();
        else do_stop();
      end
      chk("rand_err", err_flags, m_err);
      if (m_err != 4'h0) do_clear();
    end

    // reset mid-byte
    do_start();
    clk_bits(9'b1011, 4, 1'b0);
    reset = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
    m_scl = 1'b1; m_sda = 1'b1; m_active = 1'b0; m_err = '0; m_low = 0; m_bits = 0;
    q.delete();
    @(negedge system_clock);
    chk_outs_zero("midframe_reset");
    repeat (3) @(posedge system_clock);
    #1 reset = 1'b0;
    hold(H);
    do_start();
    clk_bits({8'hC3, 1'b0}, 9, 1'b1);
    do_stop();
    chk("post_reset_err", err_flags, 4'h0);

    hold(20);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
